// File: rtl/mem_responder_if.sv
// Request/response bus between the core's MEM stage and the data-memory
// responder. The requester drives the request and takes the response;
// the responder does the opposite and also reports whether it is busy.
interface mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    modport master (
        output req_valid,
        input  req_ready,
        output req_we,
        output req_addr,
        output req_wdata,
        input  rsp_valid,
        output rsp_ready,
        input  rsp_rdata,
        input  rsp_err,
        input  busy
    );

    modport slave (
        input  req_valid,
        output req_ready,
        input  req_we,
        input  req_addr,
        input  req_wdata,
        output rsp_valid,
        input  rsp_ready,
        output rsp_rdata,
        output rsp_err,
        output busy
    );
endinterface

// File: rtl/mem_responder.sv
// Word-addressed data memory with a programmable number of wait states.
// One request is in flight at a time: IDLE accepts, WAIT counts down the
// wait states, RESP presents the result until the requester takes it.
// The array itself is touched on exactly one edge per request, so a stalled
// response never rewrites memory and an aborted request never writes it.
module mem_responder #(
    parameter int DEPTH       = 1024,
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic           clk1,
    input  logic           rst_n,
    mem_responder_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    logic [3:0]  cnt;

    // Request fields captured at the accept edge
    logic        lat_we;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;

    // Registered response outputs
    logic        rsp_valid_q;
    logic [31:0] rsp_rdata_q;
    logic        rsp_err_q;

    logic [31:0] mem [DEPTH];

    logic              accept;
    logic              access_now;
    logic              acc_we;
    logic [31:0]       acc_addr;
    logic [31:0]       acc_wdata;
    logic              acc_in_range;
    logic [ADDR_W-1:0] acc_idx;

    // Ready is withheld while reset is asserted even though the state is IDLE
    assign bus.req_ready = rst_n && (state == IDLE);
    assign bus.busy      = (state != IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

    assign accept = bus.req_valid && bus.req_ready;

    // Select the fields of the access and decide whether this edge performs it
    always_comb begin
        access_now = 1'b0;
        acc_we     = lat_we;
        acc_addr   = lat_addr;
        acc_wdata  = lat_wdata;
        if (state == IDLE) begin
            // With no wait states the access happens on the accept edge
            // itself, so it must use the live request fields.
            acc_we     = bus.req_we;
            acc_addr   = bus.req_addr;
            acc_wdata  = bus.req_wdata;
            access_now = accept && (WAIT_CYCLES == 0);
        end else if (state == WAIT) begin
            access_now = (cnt == 4'd1);
        end
        // Full-width compare so that high addresses are reported, not aliased
        acc_in_range = (acc_addr < 32'(DEPTH));
        acc_idx      = acc_addr[ADDR_W-1:0];
    end

    // Capture the request at the accept edge; later bus changes are ignored
    always_ff @(posedge clk1) begin
        if (state == IDLE && accept) begin
            lat_we    <= bus.req_we;
            lat_addr  <= bus.req_addr;
            lat_wdata <= bus.req_wdata;
        end
    end

    // Array write port: only in-range stores, only on the single access edge
    always_ff @(posedge clk1) begin
        if (access_now && acc_we && acc_in_range) begin
            mem[acc_idx] <= acc_wdata;
        end
    end

    // Control FSM with registered response outputs
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            if (access_now) begin
                rsp_valid_q <= 1'b1;
                rsp_err_q   <= !acc_in_range;
                rsp_rdata_q <= (acc_in_range && !acc_we) ? mem[acc_idx] : 32'd0;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        cnt   <= 4'(WAIT_CYCLES);
                        state <= (WAIT_CYCLES == 0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    // Return to IDLE first; the next request is taken a cycle later
                    if (bus.rsp_ready) begin
                        state       <= IDLE;
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: one instance with two wait states for the main
// scenarios and one with no wait states for the back-to-back throughput case.
// Expected responses come from an address-keyed model of the memory.
module tb_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst2_n;
    logic rst0_n;

    mem_responder_if b2();
    mem_responder_if b0();

    mem_responder #(.DEPTH(1024), .ADDR_W(10), .WAIT_CYCLES(2)) u_dut2 (
        .clk1  (clk),
        .rst_n (rst2_n),
        .bus   (b2.slave)
    );

    mem_responder #(.DEPTH(1024), .ADDR_W(10), .WAIT_CYCLES(0)) u_dut0 (
        .clk1  (clk),
        .rst_n (rst0_n),
        .bus   (b0.slave)
    );

    int total = 0;
    int bad   = 0;

    logic [31:0] mdl2 [int unsigned];
    logic [31:0] w0 [4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference behaviour of one access against the two-wait-state memory
    function automatic void model_access(input logic we, input logic [31:0] addr,
                                         input logic [31:0] wd, output logic [31:0] rd,
                                         output logic er, output logic known);
        if (addr >= 32'd1024) begin
            er = 1'b1; rd = 32'd0; known = 1'b1;
        end else if (we) begin
            mdl2[addr] = wd; er = 1'b0; rd = 32'd0; known = 1'b1;
        end else begin
            er = 1'b0;
            known = mdl2.exists(addr);
            rd = known ? mdl2[addr] : 32'd0;
        end
    endfunction

    // One full transaction on the two-wait-state instance; hold = cycles of
    // response backpressure after rsp_valid is first seen.
    task automatic xact(input string tag, input logic we, input logic [31:0] addr,
                        input logic [31:0] wd, input int hold);
        logic [31:0] erd;
        logic        eer;
        logic        known;
        logic [31:0] hold_rd;
        int          n;
        int          lat;
        model_access(we, addr, wd, erd, eer, known);
        @(negedge clk);
        b2.req_valid = 1'b1;
        b2.req_we    = we;
        b2.req_addr  = addr;
        b2.req_wdata = wd;
        b2.rsp_ready = (hold == 0);
        n = 0;
        while (b2.req_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "/accepted"}, 32'(n < 50), 32'd1);
        @(posedge clk);
        @(negedge clk);
        // Scramble the request bus: the access must use the accepted fields
        b2.req_valid = 1'b0;
        b2.req_we    = 1'($urandom);
        b2.req_addr  = $urandom_range(0, 1023);
        b2.req_wdata = $urandom;
        chk({tag, "/busy"}, 32'(b2.busy), 32'd1);
        lat = 1;
        while (b2.rsp_valid !== 1'b1 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "/latency"}, 32'(lat), 32'd3);
        chk({tag, "/err"}, 32'(b2.rsp_err), 32'(eer));
        if (known) chk({tag, "/rdata"}, b2.rsp_rdata, erd);
        hold_rd = known ? erd : b2.rsp_rdata;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, "/hold_valid"}, 32'(b2.rsp_valid), 32'd1);
            chk({tag, "/hold_rdata"}, b2.rsp_rdata, hold_rd);
            chk({tag, "/hold_err"}, 32'(b2.rsp_err), 32'(eer));
            chk({tag, "/hold_ready"}, 32'(b2.req_ready), 32'd0);
        end
        b2.rsp_ready = 1'b1;
        @(negedge clk);
        chk({tag, "/valid_drop"}, 32'(b2.rsp_valid), 32'd0);
        chk({tag, "/ready_back"}, 32'(b2.req_ready), 32'd1);
        b2.rsp_ready = 1'b0;
    endtask

    // Four back-to-back accesses to addresses 0..3 on the zero-wait instance
    task automatic burst0(input string tag, input logic we);
        int k;
        int got;
        int acc_c [4];
        int rsp_c [4];
        k = 0;
        got = 0;
        for (int i = 0; i < 4; i++) begin
            acc_c[i] = 0;
            rsp_c[i] = 0;
        end
        b0.rsp_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (b0.rsp_valid === 1'b1 && got < 4) begin
                chk({tag, "/rdata"}, b0.rsp_rdata, we ? 32'd0 : w0[got]);
                chk({tag, "/err"}, 32'(b0.rsp_err), 32'd0);
                rsp_c[got] = c;
                got++;
            end
            if (b0.req_ready === 1'b1 && k < 4) begin
                b0.req_valid = 1'b1;
                b0.req_we    = we;
                b0.req_addr  = 32'(k);
                b0.req_wdata = w0[k];
                acc_c[k] = c;
                k++;
            end else begin
                b0.req_valid = 1'b0;
            end
        end
        chk({tag, "/count"}, 32'(got), 32'd4);
        for (int i = 0; i < got; i++) begin
            chk({tag, "/latency"}, 32'(rsp_c[i] - acc_c[i]), 32'd1);
        end
        if (got == 4) chk({tag, "/span"}, 32'(rsp_c[3] - acc_c[0] + 1), 32'd8);
        b0.rsp_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        int          n;

        rst2_n = 1'b0;
        rst0_n = 1'b0;
        b2.req_valid = 1'b0; b2.req_we = 1'b0; b2.req_addr = 32'd0;
        b2.req_wdata = 32'd0; b2.rsp_ready = 1'b0;
        b0.req_valid = 1'b0; b0.req_we = 1'b0; b0.req_addr = 32'd0;
        b0.req_wdata = 32'd0; b0.rsp_ready = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst/req_ready", 32'(b2.req_ready), 32'd0);
        chk("rst/rsp_valid", 32'(b2.rsp_valid), 32'd0);
        chk("rst/rsp_rdata", b2.rsp_rdata, 32'd0);
        chk("rst/rsp_err", 32'(b2.rsp_err), 32'd0);
        chk("rst/busy", 32'(b2.busy), 32'd0);
        chk("rst0/req_ready", 32'(b0.req_ready), 32'd0);
        rst2_n = 1'b1;
        rst0_n = 1'b1;
        @(negedge clk);
        chk("rel/req_ready", 32'(b2.req_ready), 32'd1);
        chk("rel/busy", 32'(b2.busy), 32'd0);
        chk("rel0/req_ready", 32'(b0.req_ready), 32'd1);

        // Store then load
        xact("sw5", 1'b1, 32'd5, 32'hDEADBEEF, 0);
        xact("lw5", 1'b0, 32'd5, 32'd0, 0);

        // Out-of-range addresses must not alias onto low words
        xact("sw1023", 1'b1, 32'd1023, 32'h77, 0);
        xact("lw1024", 1'b0, 32'd1024, 32'd0, 0);
        xact("swffff", 1'b1, 32'hFFFF_FFFF, 32'h1234, 0);
        xact("lw1023", 1'b0, 32'd1023, 32'd0, 0);

        // Response backpressure
        xact("bp_lw5", 1'b0, 32'd5, 32'd0, 10);
        xact("bp_err", 1'b0, 32'd4096, 32'd0, 3);

        // Reset during WAIT abandons the store
        xact("sw9", 1'b1, 32'd9, 32'h55, 0);
        @(negedge clk);
        b2.req_valid = 1'b1; b2.req_we = 1'b1; b2.req_addr = 32'd9;
        b2.req_wdata = 32'hAA; b2.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        b2.req_valid = 1'b0;
        chk("rstw/busy_before", 32'(b2.busy), 32'd1);
        rst2_n = 1'b0;
        #1;
        chk("rstw/rsp_valid", 32'(b2.rsp_valid), 32'd0);
        chk("rstw/rsp_rdata", b2.rsp_rdata, 32'd0);
        chk("rstw/rsp_err", 32'(b2.rsp_err), 32'd0);
        chk("rstw/busy", 32'(b2.busy), 32'd0);
        chk("rstw/req_ready", 32'(b2.req_ready), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst2_n = 1'b1;
        b2.rsp_ready = 1'b0;
        #1;
        chk("rstw/ready_after", 32'(b2.req_ready), 32'd1);
        xact("lw9", 1'b0, 32'd9, 32'd0, 0);

        // Reset during RESP drops the response
        @(negedge clk);
        b2.req_valid = 1'b1; b2.req_we = 1'b0; b2.req_addr = 32'd5; b2.rsp_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        b2.req_valid = 1'b0;
        n = 0;
        while (b2.rsp_valid !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("rstr/reached_resp", 32'(n < 50), 32'd1);
        chk("rstr/rdata_before", b2.rsp_rdata, 32'hDEADBEEF);
        rst2_n = 1'b0;
        #1;
        chk("rstr/rsp_valid", 32'(b2.rsp_valid), 32'd0);
        chk("rstr/rsp_rdata", b2.rsp_rdata, 32'd0);
        chk("rstr/busy", 32'(b2.busy), 32'd0);
        @(negedge clk);
        rst2_n = 1'b1;
        xact("lw5_after", 1'b0, 32'd5, 32'd0, 0);

        // Zero wait states, back-to-back stores then loads on 0..3
        for (int i = 0; i < 4; i++) w0[i] = $urandom;
        burst0("b2b_sw", 1'b1);
        burst0("b2b_lw", 1'b0);

        // Randomized traffic against the model
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 5))
                0, 1, 2: a = 32'($urandom_range(0, 15));
                3:       a = 32'd1023;
                4:       a = 32'd1024 + 32'($urandom_range(0, 7));
                default: a = $urandom | 32'h8000_0000;
            endcase
            xact("rnd", 1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
